// File: rtl/xor_mem_pkg.sv
// Shared definitions for the XOR multi-port RAM: address sizing, FSM encoding
// and the bank-per-row arithmetic used by xor_multiport_ram.
package xor_mem_pkg;

  localparam int DEF_WR_PORTS  = 2;
  localparam int DEF_RD_PORTS  = 4;
  localparam int BANKS_PER_ROW = DEF_WR_PORTS - 1 + DEF_RD_PORTS;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } xor_mem_state_e;

  // Number of bits needed to represent n (minimum 1).
  function automatic int log2(input int n);
    int r;
    r = 1;
    for (int i = 0; i < 31; i++) begin
      if ((n >> i) != 0) r = i + 1;
    end
    return r;
  endfunction

  function automatic int banks_per_row(input int wr_ports, input int rd_ports);
    return wr_ports - 1 + rd_ports;
  endfunction

  // Slot of the peer bank in row 'row' that serves writer 'reader'.
  function automatic int peer_slot(input int row, input int reader);
    if (reader < row) return reader;
    else if (reader > 0) return reader - 1;
    else return 0;
  endfunction

endpackage

// File: rtl/simple_dual_port_ram.sv
// One write port, one read port, synchronous read-first RAM bank.
module simple_dual_port_ram
  import xor_mem_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 512,
  localparam int AW   = log2(DEPTH - 1)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Read and write share one process so a same-address access returns the old word.
  always_ff @(posedge clk) begin
    rdata <= mem[raddr];
    if (we) mem[waddr] <= wdata;
  end

endmodule

// File: rtl/xor_multiport_ram.sv
// XOR-based multi-port RAM: WR_PORTS write ports, RD_PORTS read ports, init sweep,
// collision arbitration, back-to-back correction; XOR_MEM_FWD_EN adds T+1 read forwarding.
module xor_multiport_ram
  import xor_mem_pkg::*;
#(
  parameter int WR_PORTS = 2,
  parameter int RD_PORTS = 4,
  parameter int DEPTH    = 512,
  parameter int WIDTH    = 64,
  parameter int AW       = log2(DEPTH - 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [WR_PORTS-1:0]       wr,
  input  logic [WR_PORTS*AW-1:0]    waddr,
  input  logic [WR_PORTS*WIDTH-1:0] wdata,
  input  logic [RD_PORTS*AW-1:0]    raddr,
  output logic [RD_PORTS*WIDTH-1:0] rdata,
  output logic                      ready,
  output logic                      collision,
  input  logic                      collision_clr
);

  localparam int NB    = banks_per_row(WR_PORTS, RD_PORTS);
  localparam int NPEER = WR_PORTS - 1;

  xor_mem_state_e state, state_nx;
  logic [AW-1:0]  init_cnt;
  logic           run;
  logic           rd_ok;

  logic [AW-1:0]    wa [WR_PORTS];
  logic [WIDTH-1:0] wd [WR_PORTS];
  logic [AW-1:0]    ra [RD_PORTS];

  logic [WR_PORTS-1:0] wr_win;
  logic                coll_now;

  logic [WR_PORTS-1:0] wr_r;
  logic [AW-1:0]       wa_r [WR_PORTS];
  logic [WIDTH-1:0]    wd_r [WR_PORTS];
  logic                byp_hit  [WR_PORTS][WR_PORTS];
  logic [WIDTH-1:0]    byp_data [WR_PORTS][WR_PORTS];
  logic [WIDTH-1:0]    commit_data [WR_PORTS];

  logic [WR_PORTS-1:0] bank_we;
  logic [AW-1:0]       bank_wa [WR_PORTS];
  logic [WIDTH-1:0]    bank_wd [WR_PORTS];
  logic [WIDTH-1:0]    bank_rd [WR_PORTS][NB];

  logic [WIDTH-1:0]    rd_src [WR_PORTS][RD_PORTS];
  logic [WIDTH-1:0]    rd_xor [RD_PORTS];

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_INIT;
      init_cnt <= '0;
    end else begin
      state <= state_nx;
      if (state == ST_INIT) init_cnt <= init_cnt + AW'(1);
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_INIT: if (init_cnt == AW'(DEPTH - 1)) state_nx = ST_RUN;
      ST_RUN:  state_nx = ST_RUN;
      default: state_nx = ST_INIT;
    endcase
  end

  assign run   = (state == ST_RUN);
  assign ready = run;

  always_comb begin
    for (int p = 0; p < WR_PORTS; p++) begin
      wa[p] = waddr[p*AW +: AW];
      wd[p] = wdata[p*WIDTH +: WIDTH];
    end
    for (int r = 0; r < RD_PORTS; r++) ra[r] = raddr[r*AW +: AW];
  end

  // ---------------------------------------------------------------- arbitration
  // Lowest-index strobed port keeps an address; any higher port on it is masked.
  always_comb begin
    wr_win   = '0;
    coll_now = 1'b0;
    for (int p = 0; p < WR_PORTS; p++) begin
      wr_win[p] = wr[p] && run;
      for (int q = 0; q < WR_PORTS; q++) begin
        if (q < p && wr[p] && wr[q] && (wa[p] == wa[q])) begin
          wr_win[p] = 1'b0;
          coll_now  = run;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             collision <= 1'b0;
    else if (coll_now)      collision <= 1'b1;
    else if (collision_clr) collision <= 1'b0;
  end

  // ---------------------------------------------------------------- write staging
  // byp_* capture the word a row commits on the same edge the peer banks are read,
  // since read-first banks would otherwise hand the next writer the stale word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_r <= '0;
      for (int p = 0; p < WR_PORTS; p++) begin
        wa_r[p] <= '0;
        wd_r[p] <= '0;
        for (int q = 0; q < WR_PORTS; q++) begin
          byp_hit[p][q]  <= 1'b0;
          byp_data[p][q] <= '0;
        end
      end
    end else begin
      wr_r <= wr_win;
      for (int p = 0; p < WR_PORTS; p++) begin
        wa_r[p] <= wa[p];
        wd_r[p] <= wd[p];
        for (int q = 0; q < WR_PORTS; q++) begin
          byp_hit[p][q]  <= (q != p) && wr_r[q] && (wa_r[q] == wa[p]);
          byp_data[p][q] <= commit_data[q];
        end
      end
    end
  end

  always_comb begin
    for (int p = 0; p < WR_PORTS; p++) begin
      commit_data[p] = wd_r[p];
      for (int q = 0; q < WR_PORTS; q++) begin
        if (q != p)
          commit_data[p] = commit_data[p] ^
                           (byp_hit[p][q] ? byp_data[p][q] : bank_rd[q][peer_slot(q, p)]);
      end
    end
  end

  always_comb begin
    for (int w = 0; w < WR_PORTS; w++) begin
      if (run) begin
        bank_we[w] = wr_r[w];
        bank_wa[w] = wa_r[w];
        bank_wd[w] = commit_data[w];
      end else begin
        bank_we[w] = 1'b1;
        bank_wa[w] = init_cnt;
        bank_wd[w] = '0;
      end
    end
  end

  // ---------------------------------------------------------------- bank array
  for (genvar w = 0; w < WR_PORTS; w++) begin : g_row
    for (genvar k = 0; k < NB; k++) begin : g_bank
      logic [AW-1:0] bank_ra;
      if (k < NPEER) begin : g_peer
        assign bank_ra = wa[(k < w) ? k : k + 1];
      end else begin : g_read
        assign bank_ra = ra[k - NPEER];
      end
      simple_dual_port_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
      ) u_ram (
        .clk   (clk),
        .we    (bank_we[w]),
        .waddr (bank_wa[w]),
        .wdata (bank_wd[w]),
        .raddr (bank_ra),
        .rdata (bank_rd[w][k])
      );
    end
  end

  // ---------------------------------------------------------------- read path
`ifdef XOR_MEM_FWD_EN
  logic             fwd_hit  [WR_PORTS][RD_PORTS];
  logic [WIDTH-1:0] fwd_data [WR_PORTS][RD_PORTS];

  // A row committing on the edge its read bank is sampled returns the old word;
  // substitute the committed word for that row's contribution.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int w = 0; w < WR_PORTS; w++) begin
        for (int r = 0; r < RD_PORTS; r++) begin
          fwd_hit[w][r]  <= 1'b0;
          fwd_data[w][r] <= '0;
        end
      end
    end else begin
      for (int w = 0; w < WR_PORTS; w++) begin
        for (int r = 0; r < RD_PORTS; r++) begin
          fwd_hit[w][r]  <= wr_r[w] && (wa_r[w] == ra[r]);
          fwd_data[w][r] <= commit_data[w];
        end
      end
    end
  end

  always_comb begin
    for (int w = 0; w < WR_PORTS; w++)
      for (int r = 0; r < RD_PORTS; r++)
        rd_src[w][r] = fwd_hit[w][r] ? fwd_data[w][r] : bank_rd[w][NPEER + r];
  end
`else
  always_comb begin
    for (int w = 0; w < WR_PORTS; w++)
      for (int r = 0; r < RD_PORTS; r++)
        rd_src[w][r] = bank_rd[w][NPEER + r];
  end
`endif

  always_comb begin
    for (int r = 0; r < RD_PORTS; r++) begin
      rd_xor[r] = '0;
      for (int w = 0; w < WR_PORTS; w++) rd_xor[r] = rd_xor[r] ^ rd_src[w][r];
    end
  end

  // rd_ok lags state by one cycle so bank reads launched during the sweep never surface.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ok <= 1'b0;
      rdata <= '0;
    end else begin
      rd_ok <= run;
      for (int r = 0; r < RD_PORTS; r++)
        rdata[r*WIDTH +: WIDTH] <= rd_ok ? rd_xor[r] : '0;
    end
  end

endmodule

// File: tb/tb_xor_multiport_ram.sv
// Directed bench for xor_multiport_ram (2 write / 4 read ports, 512 x 64).
module tb_xor_multiport_ram;

  localparam int WRP = 2;
  localparam int RDP = 4;
  localparam int AW  = 9;
  localparam int W   = 64;

`ifdef XOR_MEM_FWD_EN
  localparam logic [W-1:0] RAW1_EXP = 64'hF0F0;
`else
  localparam logic [W-1:0] RAW1_EXP = 64'h0;
`endif

  logic               clk;
  logic               rst_n;
  logic [WRP-1:0]     wr;
  logic [WRP*AW-1:0]  waddr;
  logic [WRP*W-1:0]   wdata;
  logic [RDP*AW-1:0]  raddr;
  logic [RDP*W-1:0]   rdata;
  logic               ready;
  logic               collision;
  logic               collision_clr;

  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];
  int           port_q[$];

  xor_multiport_ram #(
    .WR_PORTS (WRP),
    .RD_PORTS (RDP),
    .DEPTH    (512),
    .WIDTH    (W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr            (wr),
    .waddr         (waddr),
    .wdata         (wdata),
    .raddr         (raddr),
    .rdata         (rdata),
    .ready         (ready),
    .collision     (collision),
    .collision_clr (collision_clr)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input int p, input logic [AW-1:0] a, input logic [W-1:0] d);
    wr[p] = 1'b1;
    waddr[p*AW +: AW] = a;
    wdata[p*W +: W]   = d;
  endtask

  task automatic clr_wr();
    wr = '0;
  endtask

  task automatic issue_read(input int r, input logic [AW-1:0] a, input logic [W-1:0] e);
    raddr[r*AW +: AW] = a;
    port_q.push_back(r);
    exp_q.push_back(e);
  endtask

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    assert (got === exp)
      else begin
        n_err++;
        $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
  endtask

  // scoreboard: the reads queued this cycle land two cycles later
  task automatic collect(input string tag);
    int r;
    cyc(2);
    while (exp_q.size() > 0) begin
      r = port_q.pop_front();
      check(tag, rdata[r*W +: W], exp_q.pop_front());
    end
  endtask

  task automatic wait_ready(input string tag);
    int cnt;
    cnt = 0;
    while (!ready && cnt < 2000) begin
      cyc(1);
      cnt++;
    end
    check(tag, W'(cnt), W'(512));
  endtask

  initial begin
    rst_n = 1'b0;
    wr = '0; waddr = '0; wdata = '0; raddr = '0; collision_clr = 1'b0;
    cyc(3);
    check("rst_ready", W'(ready), W'(0));
    check("rst_collision", W'(collision), W'(0));
    check("rst_rdata0", rdata[W-1:0], 64'h0);

    // init sweep length
    rst_n = 1'b1;
    wait_ready("init_cycles");
    check("idle_collision", W'(collision), W'(0));
    issue_read(0, 9'h1FF, 64'h0);
    collect("read_top_addr");

    // two ports, independent addresses
    set_wr(0, 9'd5, 64'hDEAD_BEEF);
    set_wr(1, 9'd9, 64'h1234);
    cyc(1); clr_wr(); cyc(1);
    issue_read(0, 9'd5, 64'hDEAD_BEEF);
    issue_read(1, 9'd9, 64'h1234);
    collect("two_port_write");

    // back-to-back same address, port 0 then port 1
    set_wr(0, 9'd7, 64'hAAAA);
    cyc(1); clr_wr();
    set_wr(1, 9'd7, 64'h5555);
    cyc(1); clr_wr(); cyc(1);
    issue_read(2, 9'd7, 64'h5555);
    collect("b2b_p0_p1");

    // back-to-back same address, port 1 then port 0
    set_wr(1, 9'd8, 64'h3333);
    cyc(1); clr_wr();
    set_wr(0, 9'd8, 64'hCCCC);
    cyc(1); clr_wr(); cyc(1);
    issue_read(3, 9'd8, 64'hCCCC);
    collect("b2b_p1_p0");

    // back-to-back same address, same port
    set_wr(0, 9'd50, 64'h11);
    cyc(1);
    set_wr(0, 9'd50, 64'h22);
    cyc(1); clr_wr(); cyc(1);
    issue_read(1, 9'd50, 64'h22);
    collect("b2b_same_port");

    // same-cycle collision, port 0 wins
    set_wr(0, 9'd3, 64'h1);
    set_wr(1, 9'd3, 64'h2);
    cyc(1); clr_wr();
    check("collision_set", W'(collision), W'(1));
    cyc(1);
    issue_read(0, 9'd3, 64'h1);
    collect("collision_winner");
    check("collision_sticky", W'(collision), W'(1));
    set_wr(0, 9'd4, 64'h9);
    set_wr(1, 9'd4, 64'h8);
    collision_clr = 1'b1;
    cyc(1); clr_wr(); collision_clr = 1'b0;
    check("collision_set_wins", W'(collision), W'(1));
    collision_clr = 1'b1;
    cyc(1); collision_clr = 1'b0;
    check("collision_clr", W'(collision), W'(0));

    // read in the same cycle as the write sees the old word
    set_wr(0, 9'd20, 64'h77);
    issue_read(0, 9'd20, 64'h0);
    cyc(1); clr_wr();
    collect("raw_dist0");

    // read one cycle after the write
    set_wr(0, 9'd12, 64'hF0F0);
    cyc(1); clr_wr();
    issue_read(2, 9'd12, RAW1_EXP);
    collect("raw_dist1");
    issue_read(2, 9'd12, 64'hF0F0);
    collect("raw_dist2_after");

    // sustained writes on both ports, then all four read ports at once
    for (int i = 0; i < 4; i++) begin
      set_wr(0, AW'(100 + i), 64'hA0 + 64'(i));
      set_wr(1, AW'(200 + i), 64'hB0 + 64'(i));
      cyc(1);
    end
    clr_wr(); cyc(1);
    issue_read(0, 9'd100, 64'hA0);
    issue_read(1, 9'd103, 64'hA3);
    issue_read(2, 9'd201, 64'hB1);
    issue_read(3, 9'd203, 64'hB3);
    collect("sustained");
    issue_read(0, 9'd5, 64'hDEAD_BEEF);
    issue_read(1, 9'd9, 64'h1234);
    issue_read(2, 9'd7, 64'h5555);
    issue_read(3, 9'd3, 64'h1);
    collect("four_port_read");

    // reset in the middle of a write burst
    for (int i = 0; i < 4; i++) begin
      set_wr(0, AW'(40 + i), 64'h100 + 64'(i));
      set_wr(1, (i == 1) ? AW'(41) : AW'(60 + i), 64'h200 + 64'(i));
      cyc(1);
    end
    rst_n = 1'b0;
    #1;
    check("midrst_ready", W'(ready), W'(0));
    check("midrst_collision", W'(collision), W'(0));
    clr_wr();
    cyc(3);
    rst_n = 1'b1;
    wait_ready("midrst_init_cycles");
    issue_read(0, 9'd40, 64'h0);
    issue_read(1, 9'd42, 64'h0);
    issue_read(2, 9'd5, 64'h0);
    issue_read(3, 9'd12, 64'h0);
    collect("midrst_cleared");
    issue_read(0, 9'd7, 64'h0);
    issue_read(1, 9'd61, 64'h0);
    issue_read(2, 9'd100, 64'h0);
    issue_read(3, 9'd43, 64'h0);
    collect("midrst_cleared2");

    // fresh write after the sweep still works
    set_wr(1, 9'd40, 64'h0BAD_F00D);
    cyc(1); clr_wr(); cyc(1);
    issue_read(0, 9'd40, 64'h0BAD_F00D);
    collect("post_reset_write");

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/xor_multiport_ram.md
# xor_multiport_ram

Parametrised XOR-based multi-port RAM with independent counts of write ports and read ports. It is built from simple dual-port RAM banks and adds four things: a self-clearing init sweep, same-cycle write-collision arbitration with a sticky error flag, correction for back-to-back writes to the same address, and optional read-after-write forwarding. It is the drop-in successor to the 4-port symmetric XOR memory, for register-file and scoreboard use in the accelerator datapath.

## Interface
- WR_PORTS, 2: number of write ports (≥1)
- RD_PORTS, 4: number of read ports (≥1)
- DEPTH, 512: words per port
- WIDTH, 64: bits per word
- AW, log2(DEPTH-1): address width
- clk  input  1  single clock, all logic rising-edge
- rst_n  input  1  asynchronous active-low reset
- wr  input  WR_PORTS  per-port write strobe, bit 0 = port 0
- waddr  input  WR_PORTS*AW  write addresses, port p at [(p+1)*AW-1 -: AW]
- wdata  input  WR_PORTS*WIDTH  write data, same packing
- raddr  input  RD_PORTS*AW  read addresses
- rdata  output  RD_PORTS*WIDTH  read data, registered
- ready  output  1  high once the init sweep completes
- collision  output  1  sticky; set on a same-cycle same-address write conflict
- collision_clr  input  1  synchronous clear of collision

## Operation
- Bank array: WR_PORTS rows. Row w has WR_PORTS-1 "peer" banks plus RD_PORTS "read" banks. All banks in row w are written identically.
- Stored value: word(a) = XOR over rows w of bank_w(a).
- FSM with states INIT and RUN. Reset enters INIT with counter = 0.
- INIT: every bank is written with 0 at the counter address; the counter increments each cycle. After DEPTH-1 the FSM moves to RUN.
- During INIT, wr is ignored, ready = 0 and rdata = 0.
- RUN, write on port p, cycle T:
  - wr, waddr and wdata are registered.
  - The peer banks of the other rows are read at waddr.
  - At T+1, row p is written with wdata_r XOR (peer reads of all rows ≠ p).
- RUN, read port r, cycle T:
  - All rows' read banks are read at raddr[r].
  - At T+1 the results are XORed and registered into rdata[r].
- Collision: if two or more strobed ports share an address in one cycle, the lowest-index port wins. Higher ports are masked and collision is set.
- collision_clr clears the flag. If clear and a new collision happen in the same cycle, set wins.
- Back-to-back write correction (always present): if the write at T+1 hits the address being committed at T+1 by row q, the peer read of row q is replaced by the value being committed. This keeps T/T+1 same-address writes from different ports coherent.
- Bank RAMs are read-first.

## Timing
- Reset values: rdata = 0, ready = 0, collision = 0, FSM = INIT, all staging registers = 0.
- Init duration: DEPTH cycles after rst_n deasserts. ready rises on the first RUN cycle.
- Read latency: 2. raddr at T gives rdata at T+2.
- Write visibility without forwarding:
  - A read issued at T+2 or later returns data written at T.
  - A read issued at T+1 returns the old value.
  - A read issued at T returns the old value.
- Write throughput: one write per port per cycle, sustained.
- Reset asserted mid-operation: the FSM returns to INIT immediately and the sweep restarts. Any in-flight write is dropped, and contents read as 0 after ready.
- Address range: an address ≥ DEPTH is truncated to AW bits; nothing wraps beyond that.

## Configuration
- XOR_MEM_FWD_EN defined: a read issued at T+1 whose address matches a write committing at T+1 returns the new value.
- With forwarding, effective read-after-write distance is 1 cycle. The comparator uses the registered write address against raddr, one comparator per (row, read port).
- Not defined: no comparators, and T+1 reads return stale data as listed in Timing.

## Structure
- xor_mem_pkg holds:
  - the log2 function
  - the FSM state encoding (INIT, RUN)
  - a localparam computing the bank count per row, WR_PORTS-1+RD_PORTS
- One sub-module: the existing simple_dual_port_ram (WIDTH, DEPTH), instantiated WR_PORTS*(WR_PORTS-1+RD_PORTS) times.
- Arbitration, correction, forwarding and the FSM stay in the top module.

## Test plan
- Reset then idle: count cycles until ready. Expect ready = 1 exactly 512 cycles after rst_n rises. Read addr 0x1FF gives rdata 0.
- Write 0xDEAD_BEEF port 0 addr 5 at T, 0x1234 port 1 addr 9 at T. Read both at T+2: expect 0xDEADBEEF and 0x1234 at T+4.
- Back-to-back same address:
  - Port 0 writes 0xAAAA to addr 7 at T.
  - Port 1 writes 0x5555 to addr 7 at T+1.
  - A read at T+3 returns 0x5555.
- Same-cycle collision: port 0 writes 0x1 and port 1 writes 0x2, both to addr 3. Expect collision = 1 at the next cycle and a later read of 0x1. collision_clr drops collision to 0.
- Read-after-write at distance 1, addr 12 value 0xF0F0:
  - With XOR_MEM_FWD_EN, the read returns 0xF0F0.
  - Without it, the read returns the prior value 0.
- Reset asserted mid-write burst, then released. Expect ready low for 512 cycles, and all previously written addresses read 0.
